// File: rtl/difficulty_gate_if.sv
// Hash stream between the SHA-256 core (master) and difficulty_gate (slave).
interface difficulty_gate_if #(
    parameter int NONCE_WIDTH = 32
);
    logic                   hash_valid;
    logic                   hash_ready;
    logic [15:0]            hash_msw;
    logic [NONCE_WIDTH-1:0] hash_nonce;

    modport master (output hash_valid, hash_msw, hash_nonce, input hash_ready);
    modport slave  (input hash_valid, hash_msw, hash_nonce, output hash_ready);
endinterface

// File: rtl/difficulty_gate.sv
// Tests each hash's top 16 bits against a leading-zero mask fetched from difficulty_map,
// holds the first winning nonce until acknowledged, and counts checked hashes.
module difficulty_gate #(
    parameter int NONCE_WIDTH = 32,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [3:0]             cfg_difficulty,
    input  logic                   cfg_load,
    output logic                   map_en,
    output logic [3:0]             map_addr,
    input  logic [15:0]            map_difficulty,
    difficulty_gate_if.slave       hash,
    output logic                   hit,
    output logic [NONCE_WIDTH-1:0] hit_nonce,
    input  logic                   hit_ack,
    output logic [CNT_WIDTH-1:0]   checked_count
);

    typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, ARMED, HIT} state_t;

    state_t      state, state_nx;
    logic [15:0] mask;
    logic        ready;
    logic        xfer;
    logic        win;

    assign win = ((hash.hash_msw & mask) == 16'h0000);
    assign hit = (state == HIT);

    always_comb begin
        state_nx = state;
        map_en   = 1'b0;
        ready    = 1'b0;
        case (state)
            IDLE:    state_nx = IDLE;
            FETCH: begin
                map_en   = 1'b1;
                state_nx = CAPTURE;
            end
            CAPTURE: state_nx = ARMED;
            ARMED: begin
                ready = 1'b1;
                if (hash.hash_valid && win) state_nx = HIT;
            end
            HIT:     if (hit_ack) state_nx = ARMED;
            default: state_nx = IDLE;
        endcase
        // A reload overrides any same-cycle transfer or acknowledge.
        if (cfg_load) state_nx = FETCH;
        xfer            = ready && hash.hash_valid && !cfg_load;
        hash.hash_ready = ready;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            mask          <= '0;
            map_addr      <= '0;
            hit_nonce     <= '0;
            checked_count <= '0;
        end else begin
            state <= state_nx;
            if (cfg_load) begin
                map_addr      <= cfg_difficulty;
                checked_count <= '0;
            end else begin
                if (state == CAPTURE) mask <= map_difficulty;
                if (xfer) begin
                    if (checked_count != '1) checked_count <= checked_count + CNT_WIDTH'(1);
                    if (win) hit_nonce <= hash.hash_nonce;
                end
            end
        end
    end

endmodule
